msg_depacketizer: RTL

// - Downstream neighbour of the message parser. Captures each parsed message
//   (256-bit data + 32-bit bytemask, single-cycle valid, no backpressure).
// - Buffers messages in a small FIFO.
// - Re-emits each message as 64-bit beats on a valid/ready stream with
//   sop/eop/empty framing, for the egress logic.

---
 rtl/msg_pkg.sv | 36 +++
 rtl/msg_depacketizer_if.sv | 31 +++
 rtl/msg_depacketizer_fifo.sv | 69 ++++++
 rtl/msg_depacketizer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : msg_pkg
//  Description : Types and constants shared by the message parser and the
//                message depacketizer: message entry struct, FSM state enum
//                and a bytemask population-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package msg_pkg;

  localparam int MSG_BYTES  = 32;
  localparam int BEAT_BYTES = 8;
  localparam int LEN_W      = 6;                      // holds 0..32
  localparam int BEAT_W     = 8 * BEAT_BYTES;

  typedef struct packed {
    logic [0:8*MSG_BYTES-1] data;
    logic [LEN_W-1:0]       len;
  } msg_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } depack_state_t;

  function automatic logic [LEN_W-1:0] popcount_mask(input logic [MSG_BYTES-1:0] mask);
    logic [LEN_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < MSG_BYTES; k++) begin
      cnt = cnt + LEN_W'(mask[k]);
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_depacketizer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : msg_depacketizer_if
//  Description : 64-bit beat stream with valid/ready handshake and
//                sop/eop/empty framing.
//  Signals     : m_valid, m_ready, m_data[0:63], m_sop, m_eop, m_empty[2:0]
//  Modports    : master (depacketizer side), slave (egress side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface msg_depacketizer_if;
  import msg_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [0:BEAT_W-1] m_data;
  logic              m_sop;
  logic              m_eop;
  logic [2:0]        m_empty;

  modport master (
    output m_valid, m_data, m_sop, m_eop, m_empty,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_sop, m_eop, m_empty,
    output m_ready
  );

endinterface
`default_nettype wire

// File: rtl/msg_depacketizer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : msg_fifo
//  Description : Synchronous show-ahead FIFO of msg_entry_t. Head is visible
//                whenever the FIFO is not empty. Push while full and pop
//                while empty are ignored.
//  Ports       : clk, reset_n (async, active-low), push, wr_entry, pop,
//                head, full, empty, level
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_fifo
  import msg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  msg_entry_t             wr_entry,
  input  logic                   pop,
  output msg_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  msg_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_entry;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/msg_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module      : msg_depacketizer
//  Description : Captures parsed 32-byte messages (data + bytemask), buffers
//                them in a small FIFO and re-emits each as 64-bit beats with
//                sop/eop/empty framing on a valid/ready stream.
//  Ports       : clk, reset_n (async, active-low)
//                in_valid, in_data[0:255], in_bytemask[31:0]  - message input
//                m_if (master)                                - beat stream
//                fifo_level, overflow, mask_err               - status
//                stat_msg_cnt, stat_drop_cnt                  - optional stats
//  Config      : define MSG_DEPACK_STATS_EN to add the saturating statistics
//                counters and their ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_depacketizer
  import msg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [0:8*MSG_BYTES-1] in_data,
  input  logic [MSG_BYTES-1:0]   in_bytemask,
  msg_depacketizer_if.master     m_if,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   mask_err
`ifdef MSG_DEPACK_STATS_EN
  ,
  output logic [15:0]            stat_msg_cnt,
  output logic [15:0]            stat_drop_cnt
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  depack_state_t        r_state, w_state_nxt;
  logic [1:0]           r_beat_idx, w_beat_idx_nxt;
  logic                 r_overflow, r_mask_err;

  logic [LEN_W-1:0]     w_len;
  logic [MSG_BYTES-1:0] w_exp_mask;
  logic                 w_msg_ok, w_push, w_drop, w_mask_bad, w_pop;
  msg_entry_t           w_wr_entry, w_head;
  logic                 w_full, w_empty;
  logic [LVL_W-1:0]     w_level;
  logic [2:0]           w_nbeats;
  logic [1:0]           w_last_idx;
  logic                 w_is_eop;

  // Write side: length from popcount, full is the registered pre-pop flag.
  assign w_len      = popcount_mask(in_bytemask);
  assign w_exp_mask = (w_len >= LEN_W'(MSG_BYTES)) ? '1 : ((32'h1 << w_len) - 32'h1);
  assign w_msg_ok   = in_valid && (w_len != '0);
  assign w_push     = w_msg_ok && !w_full;
  assign w_drop     = w_msg_ok && w_full;
  assign w_mask_bad = in_valid && (in_bytemask != w_exp_mask);
  assign w_wr_entry = '{data: in_data, len: w_len};

  msg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (w_push),
    .wr_entry (w_wr_entry),
    .pop      (w_pop),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .level    (w_level)
  );

  assign fifo_level = w_level;
  assign overflow   = r_overflow;
  assign mask_err   = r_mask_err;

  // Beat framing from the head entry: nbeats = ceil(len/8), 1..4.
  assign w_nbeats   = 3'((w_head.len + LEN_W'(7)) >> 3);
  assign w_last_idx = 2'(w_nbeats - 3'd1);
  assign w_is_eop   = (r_beat_idx == w_last_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_beat_idx <= '0;
      r_overflow <= 1'b0;
      r_mask_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_idx <= w_beat_idx_nxt;
      if (w_drop)     r_overflow <= 1'b1;
      if (w_mask_bad) r_mask_err <= 1'b1;
    end
  end

  // Outputs are driven only in SEND so they read zero during reset/IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_idx_nxt = r_beat_idx;
    w_pop          = 1'b0;
    m_if.m_valid   = 1'b0;
    m_if.m_data    = '0;
    m_if.m_sop     = 1'b0;
    m_if.m_eop     = 1'b0;
    m_if.m_empty   = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt    = SEND;
          w_beat_idx_nxt = '0;
        end
      end
      SEND: begin
        m_if.m_valid = 1'b1;
        m_if.m_data  = w_head.data[{r_beat_idx, 6'b000000} +: BEAT_W];
        m_if.m_sop   = (r_beat_idx == 2'd0);
        m_if.m_eop   = w_is_eop;
        m_if.m_empty = w_is_eop ? 3'({w_nbeats, 3'b000} - w_head.len) : 3'd0;
        if (m_if.m_ready) begin
          if (w_is_eop) begin
            w_pop          = 1'b1;
            w_beat_idx_nxt = '0;
            // Another message already queued: continue without a bubble.
            w_state_nxt    = (w_level > LVL_W'(1)) ? SEND : IDLE;
          end else begin
            w_beat_idx_nxt = r_beat_idx + 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_beat_idx_nxt = '0;
      end
    endcase
  end

`ifdef MSG_DEPACK_STATS_EN
  logic [15:0] r_msg_cnt, r_drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop && (r_msg_cnt != 16'hFFFF))   r_msg_cnt  <= r_msg_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign stat_msg_cnt  = r_msg_cnt;
  assign stat_drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire
